// File: rtl/pspin_alloc_pkg.sv
// Shared types and helpers for the PsPIN packet buffer ring allocator.
// Slot entries use a fixed-width layout so the table can be reused across address widths.
package pspin_alloc_pkg;

   localparam int SLOT_FIELD_W      = 64;
   localparam int DEF_ALIGN_LOG2    = 6;
   localparam int DEF_BUF_SIZE_LOG2 = 15;

   typedef struct packed {
      logic [SLOT_FIELD_W-1:0] addr;
      logic [SLOT_FIELD_W-1:0] size;
      logic                    done;
   } slot_entry_t;

   // Round val up to the next multiple of 2**lg.
   function automatic logic [31:0] roundup_pow2(input logic [31:0] val, input int unsigned lg);
      logic [31:0] mask;
      mask = (32'd1 << lg) - 32'd1;
      return (val + mask) & ~mask;
   endfunction

endpackage

// File: rtl/pspin_alloc_slot_table.sv
// Circular table of outstanding allocations: push at tail, mark done by address (CAM),
// pop the head once it is done so space is reclaimed strictly in allocation order.
module pspin_alloc_slot_table
   import pspin_alloc_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned SIZE_W = 16,
   localparam int unsigned IDX_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_valid,
   input  logic [SLOT_FIELD_W-1:0] push_addr,
   input  logic [SLOT_FIELD_W-1:0] push_size,
   input  logic                    free_valid,
   input  logic [ADDR_W-1:0]       free_addr,
   output logic                    free_err,
   output logic                    pop_valid,
   output logic [SIZE_W-1:0]       pop_size,
   output logic [CNT_W-1:0]        count
);

   slot_entry_t      slots [DEPTH];
   logic [DEPTH-1:0] occ;
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [DEPTH-1:0] match;
   logic [CNT_W-1:0] n_match;
   logic             single;

   // Only occupied, not-yet-done slots are candidates; a slot pushed this cycle is not yet occupied.
   always_comb begin
      match   = '0;
      n_match = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         match[i] = occ[i] && !slots[i].done && (slots[i].addr == SLOT_FIELD_W'(free_addr));
         n_match  = n_match + CNT_W'(match[i]);
      end
      single = (n_match == CNT_W'(1));
   end

   assign pop_valid = occ[head] && slots[head].done;
   assign pop_size  = slots[head].size[SIZE_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         free_err <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
      end else begin
         free_err <= free_valid && !single;
         if (free_valid && single) begin
            for (int i = 0; i < int'(DEPTH); i++)
               if (match[i]) slots[i].done <= 1'b1;
         end
         if (pop_valid) begin
            occ[head] <= 1'b0;
            head      <= head + IDX_W'(1);
         end
         // The parent never pushes while full, so tail cannot alias a popping head.
         if (push_valid) begin
            slots[tail] <= '{addr: push_addr, size: push_size, done: 1'b0};
            occ[tail]   <= 1'b1;
            tail        <= tail + IDX_W'(1);
         end
         count <= count + CNT_W'(push_valid) - CNT_W'(pop_valid);
      end
   end

endmodule

// File: rtl/pspin_pkt_buf_ring_alloc.sv
// Ring allocator for the PsPIN L2 packet buffer: assigns aligned contiguous regions to
// incoming frames, emits the ingress write descriptor and reclaims space on completion.
module pspin_pkt_buf_ring_alloc
   import pspin_alloc_pkg::*;
#(
   parameter int unsigned                AXI_ADDR_WIDTH = 32,
   parameter int unsigned                LEN_WIDTH      = 20,
   parameter int unsigned                TAG_WIDTH      = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0]  BUF_BASE       = 32'h1C10_0000,
   parameter int unsigned                BUF_SIZE       = 1 << DEF_BUF_SIZE_LOG2,
   parameter int unsigned                ALIGN          = 1 << DEF_ALIGN_LOG2,
   parameter int unsigned                MAX_INFLIGHT   = 16,
   parameter int unsigned                MTU            = 1500
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LEN_WIDTH-1:0]              alloc_len,
   input  logic [TAG_WIDTH-1:0]              alloc_tag,
   input  logic                              alloc_valid,
   output logic                              alloc_ready,
   output logic [AXI_ADDR_WIDTH-1:0]         write_desc_addr,
   output logic [LEN_WIDTH-1:0]              write_desc_len,
   output logic [TAG_WIDTH-1:0]              write_desc_tag,
   output logic                              write_desc_valid,
   input  logic                              write_desc_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]         free_addr,
   input  logic                              free_valid,
   output logic [$clog2(BUF_SIZE):0]         used_bytes,
   output logic [$clog2(MAX_INFLIGHT):0]     inflight,
   output logic                              alloc_err,
   output logic                              free_err
);

   localparam int unsigned OFF_W      = $clog2(BUF_SIZE);
   localparam int unsigned USED_W     = OFF_W + 1;
   localparam int unsigned CNT_W      = $clog2(MAX_INFLIGHT) + 1;
   localparam int unsigned ALIGN_LOG2 = $clog2(ALIGN);

   logic [OFF_W-1:0]          wr_off;
   logic [USED_W-1:0]         used_q;
   logic [31:0]               sz;
   logic [31:0]               pad;
   logic [31:0]               need;
   logic                      wrap;
   logic                      fits;
   logic                      too_long;
   logic                      accept;
   logic                      push;
   logic [AXI_ADDR_WIDTH-1:0] region_addr;
   logic                      pop_valid;
   logic [USED_W-1:0]         pop_size;
   logic [CNT_W-1:0]          count;

   // A region that would run past the end skips the tail remainder (pad) and restarts at base.
   always_comb begin
      sz = roundup_pow2(32'(alloc_len), ALIGN_LOG2);
      if (sz < 32'(ALIGN)) sz = 32'(ALIGN);
      wrap        = (32'(wr_off) + sz) > 32'(BUF_SIZE);
      pad         = wrap ? (32'(BUF_SIZE) - 32'(wr_off)) : 32'd0;
      need        = pad + sz;
      region_addr = wrap ? BUF_BASE : (BUF_BASE + AXI_ADDR_WIDTH'(wr_off));
      fits        = ((32'(used_q) + need) <= 32'(BUF_SIZE)) && (count < CNT_W'(MAX_INFLIGHT));
      too_long    = 32'(alloc_len) > 32'(MTU);
   end

   // Handshake: a transfer happens on a cycle where both valid and ready are high; neither
   // side may make valid depend on ready, and a raised write_desc_valid holds until accepted.
   assign alloc_ready = !rst && (!write_desc_valid || write_desc_ready) && (fits || too_long);
   assign accept      = alloc_valid && alloc_ready;
   assign push        = accept && !too_long;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_off           <= '0;
         used_q           <= '0;
         write_desc_valid <= 1'b0;
         write_desc_addr  <= BUF_BASE;
         write_desc_len   <= '0;
         write_desc_tag   <= '0;
         alloc_err        <= 1'b0;
      end else begin
         alloc_err <= accept && too_long;
         if (push) wr_off <= wr_off + OFF_W'(need);
         used_q <= used_q + (push ? USED_W'(need) : '0) - (pop_valid ? pop_size : '0);
         if (push) begin
            write_desc_valid <= 1'b1;
            write_desc_addr  <= region_addr;
            write_desc_len   <= alloc_len;
            write_desc_tag   <= alloc_tag;
         end else if (write_desc_ready) begin
            write_desc_valid <= 1'b0;
         end
      end
   end

   pspin_alloc_slot_table #(
      .DEPTH  (MAX_INFLIGHT),
      .ADDR_W (AXI_ADDR_WIDTH),
      .SIZE_W (USED_W)
   ) u_slot_table (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push),
      .push_addr  (SLOT_FIELD_W'(region_addr)),
      .push_size  (SLOT_FIELD_W'(need)),
      .free_valid (free_valid),
      .free_addr  (free_addr),
      .free_err   (free_err),
      .pop_valid  (pop_valid),
      .pop_size   (pop_size),
      .count      (count)
   );

   assign used_bytes = used_q;
   assign inflight   = count;

endmodule

// File: tb/tb_pspin_pkt_buf_ring_alloc.sv
// Directed bench for the packet buffer ring allocator in a 4 KiB / 4-slot configuration.
module tb_pspin_pkt_buf_ring_alloc;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] alloc_len;
   logic [31:0] alloc_tag;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [31:0] write_desc_addr;
   logic [19:0] write_desc_len;
   logic [31:0] write_desc_tag;
   logic        write_desc_valid;
   logic        write_desc_ready;
   logic [31:0] free_addr;
   logic        free_valid;
   logic [12:0] used_bytes;
   logic [2:0]  inflight;
   logic        alloc_err;
   logic        free_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pspin_pkt_buf_ring_alloc #(
      .BUF_BASE     (32'h1000),
      .BUF_SIZE     (4096),
      .ALIGN        (64),
      .MAX_INFLIGHT (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_len        (alloc_len),
      .alloc_tag        (alloc_tag),
      .alloc_valid      (alloc_valid),
      .alloc_ready      (alloc_ready),
      .write_desc_addr  (write_desc_addr),
      .write_desc_len   (write_desc_len),
      .write_desc_tag   (write_desc_tag),
      .write_desc_valid (write_desc_valid),
      .write_desc_ready (write_desc_ready),
      .free_addr        (free_addr),
      .free_valid       (free_valid),
      .used_bytes       (used_bytes),
      .inflight         (inflight),
      .alloc_err        (alloc_err),
      .free_err         (free_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      alloc_valid = 1'b0;
      free_valid  = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Returns one tick after the accepting edge.
   task automatic do_alloc(input logic [19:0] len, input logic [31:0] tag);
      alloc_len   = len;
      alloc_tag   = tag;
      alloc_valid = 1'b1;
      #1;
      for (int n = 0; n < 20 && !alloc_ready; n++) step();
      total++;
      if (alloc_ready !== 1'b1) begin
         bad++;
         $display("FAIL alloc_wait len=%0d: alloc_ready=%b required 1", len, alloc_ready);
      end
      step();
      alloc_valid = 1'b0;
   endtask

   task automatic do_free(input logic [31:0] addr);
      free_addr  = addr;
      free_valid = 1'b1;
      step();
      free_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (write_desc_valid !== 1'b0) begin bad++; $display("FAIL reset_wdv: got %b want 0", write_desc_valid); end
      total++; if (write_desc_addr !== 32'h1000) begin bad++; $display("FAIL reset_addr: got %h want 1000", write_desc_addr); end
      total++; if (write_desc_len !== 20'd0 || write_desc_tag !== 32'd0) begin bad++; $display("FAIL reset_len_tag: got %0d/%h want 0/0", write_desc_len, write_desc_tag); end
      total++; if (used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", used_bytes, inflight); end
      total++; if (alloc_err !== 1'b0 || free_err !== 1'b0) begin bad++; $display("FAIL reset_errs: got %b/%b want 0/0", alloc_err, free_err); end
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", alloc_ready); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      do_alloc(20'd100, 32'hAB);
      total++; if (write_desc_valid !== 1'b1) begin bad++; $display("FAIL single_wdv: got %b want 1", write_desc_valid); end
      total++; if ({write_desc_addr, write_desc_len, write_desc_tag} !== {32'h1000, 20'd100, 32'hAB}) begin bad++; $display("FAIL single_desc: got %h/%0d/%h want 1000/100/ab", write_desc_addr, write_desc_len, write_desc_tag); end
      total++; if (used_bytes !== 13'd128 || inflight !== 3'd1) begin bad++; $display("FAIL single_counts: got %0d/%0d want 128/1", used_bytes, inflight); end
      step();
      total++; if (write_desc_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", write_desc_valid); end
   endtask

   task automatic test_wrap();
      apply_reset();
      do_alloc(20'd1280, 32'h1);
      do_alloc(20'd1280, 32'h2);
      do_alloc(20'd1280, 32'h3);
      total++; if (write_desc_addr !== 32'h1A00 || used_bytes !== 13'd3840) begin bad++; $display("FAIL wrap_fill: got %h/%0d want 1a00/3840", write_desc_addr, used_bytes); end
      do_free(32'h1000);
      do_free(32'h1500);
      do_free(32'h1A00);
      step();
      step();
      total++; if (used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL wrap_drain: got %0d/%0d want 0/0", used_bytes, inflight); end
      do_alloc(20'd300, 32'h33);
      total++; if (write_desc_addr !== 32'h1000 || write_desc_len !== 20'd300) begin bad++; $display("FAIL wrap_addr: got %h/%0d want 1000/300", write_desc_addr, write_desc_len); end
      total++; if (used_bytes !== 13'd576 || inflight !== 3'd1) begin bad++; $display("FAIL wrap_used: got %0d/%0d want 576/1", used_bytes, inflight); end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 4; i++) do_alloc(20'd64, 32'(i));
      total++; if (inflight !== 3'd4 || used_bytes !== 13'd256) begin bad++; $display("FAIL full_counts: got %0d/%0d want 4/256", inflight, used_bytes); end
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", alloc_ready); end
      alloc_valid = 1'b1;
      step();
      alloc_valid = 1'b0;
      total++; if (inflight !== 3'd4) begin bad++; $display("FAIL full_no_accept: got %0d want 4", inflight); end
      do_free(32'h1000);
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready_early: got %b want 0", alloc_ready); end
      step();
      total++; if (alloc_ready !== 1'b1 || inflight !== 3'd3) begin bad++; $display("FAIL full_ready_late: got %b/%0d want 1/3", alloc_ready, inflight); end
   endtask

   task automatic test_out_of_order();
      apply_reset();
      do_alloc(20'd64, 32'hA);
      do_alloc(20'd128, 32'hB);
      do_alloc(20'd64, 32'hC);
      total++; if (write_desc_addr !== 32'h10C0 || write_desc_tag !== 32'hC) begin bad++; $display("FAIL ooo_back_to_back: got %h/%h want 10c0/c", write_desc_addr, write_desc_tag); end
      do_free(32'h10C0);
      do_free(32'h1040);
      step();
      total++; if (used_bytes !== 13'd256 || inflight !== 3'd3 || free_err !== 1'b0) begin bad++; $display("FAIL ooo_hold: got %0d/%0d/%b want 256/3/0", used_bytes, inflight, free_err); end
      do_free(32'h1000);
      total++; if (used_bytes !== 13'd256) begin bad++; $display("FAIL ooo_a_done: got %0d want 256", used_bytes); end
      step();
      total++; if (used_bytes !== 13'd192) begin bad++; $display("FAIL ooo_retire_a: got %0d want 192", used_bytes); end
      step();
      total++; if (used_bytes !== 13'd64) begin bad++; $display("FAIL ooo_retire_b: got %0d want 64", used_bytes); end
      step();
      total++; if (used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL ooo_retire_c: got %0d/%0d want 0/0", used_bytes, inflight); end
   endtask

   task automatic test_errors();
      apply_reset();
      alloc_len   = 20'd1501;
      alloc_valid = 1'b1;
      #1;
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL err_ready: got %b want 1", alloc_ready); end
      step();
      alloc_valid = 1'b0;
      total++; if (alloc_err !== 1'b1 || write_desc_valid !== 1'b0) begin bad++; $display("FAIL err_alloc: got %b/%b want 1/0", alloc_err, write_desc_valid); end
      total++; if (used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL err_alloc_state: got %0d/%0d want 0/0", used_bytes, inflight); end
      step();
      total++; if (alloc_err !== 1'b0) begin bad++; $display("FAIL err_alloc_pulse: got %b want 0", alloc_err); end
      do_free(32'h1040);
      total++; if (free_err !== 1'b1 || used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL err_free: got %b/%0d/%0d want 1/0/0", free_err, used_bytes, inflight); end
      step();
      total++; if (free_err !== 1'b0) begin bad++; $display("FAIL err_free_pulse: got %b want 0", free_err); end
      do_alloc(20'd1500, 32'h7);
      total++; if (alloc_err !== 1'b0 || write_desc_len !== 20'd1500 || used_bytes !== 13'd1536) begin bad++; $display("FAIL err_mtu_edge: got %b/%0d/%0d want 0/1500/1536", alloc_err, write_desc_len, used_bytes); end
      do_alloc(20'd0, 32'h8);
      total++; if (write_desc_addr !== 32'h1600 || used_bytes !== 13'd1600) begin bad++; $display("FAIL err_zero_len: got %h/%0d want 1600/1600", write_desc_addr, used_bytes); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      write_desc_ready = 1'b0;
      do_alloc(20'd100, 32'h5);
      step();
      total++; if (write_desc_valid !== 1'b1 || write_desc_addr !== 32'h1000) begin bad++; $display("FAIL mid_hold: got %b/%h want 1/1000", write_desc_valid, write_desc_addr); end
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL mid_stall: got %b want 0", alloc_ready); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (write_desc_valid !== 1'b0 || used_bytes !== 13'd0 || inflight !== 3'd0) begin bad++; $display("FAIL mid_reset: got %b/%0d/%0d want 0/0/0", write_desc_valid, used_bytes, inflight); end
      write_desc_ready = 1'b1;
      do_free(32'h1000);
      total++; if (free_err !== 1'b1) begin bad++; $display("FAIL mid_stale_free: got %b want 1", free_err); end
      do_alloc(20'd200, 32'h6);
      total++; if (write_desc_addr !== 32'h1000 || used_bytes !== 13'd256) begin bad++; $display("FAIL mid_realloc: got %h/%0d want 1000/256", write_desc_addr, used_bytes); end
   endtask

   initial begin
      rst              = 1'b1;
      alloc_len        = '0;
      alloc_tag        = '0;
      alloc_valid      = 1'b0;
      free_addr        = '0;
      free_valid       = 1'b0;
      write_desc_ready = 1'b1;
      test_reset();
      test_single();
      test_wrap();
      test_full();
      test_out_of_order();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pspin_pkt_buf_ring_alloc.md
# pspin_pkt_buf_ring_alloc

Ring allocator for the PsPIN packet buffer. It takes per-frame length requests from the matching engine, assigns each an aligned, contiguous region of the L2 packet buffer, and issues the write descriptor that starts the ingress DMA. Regions are reclaimed when PsPIN reports handler completion. Completions may arrive out of order; space is reclaimed in allocation order.

## Interface

Parameters:
- `AXI_ADDR_WIDTH`, 32: address width of descriptors.
- `LEN_WIDTH`, 20: length width.
- `TAG_WIDTH`, 32: tag width, passed through unchanged.
- `BUF_BASE`, 32'h1C10_0000: base address of the packet buffer.
- `BUF_SIZE`, 32768: buffer size in bytes. Power of two, multiple of `ALIGN`.
- `ALIGN`, 64: allocation granule in bytes. Power of two.
- `MAX_INFLIGHT`, 16: slot table depth, i.e. the maximum number of outstanding allocations.
- `MTU`, 1500: largest length accepted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `alloc_len` in `LEN_WIDTH`: requested frame length in bytes.
- `alloc_tag` in `TAG_WIDTH`: request tag.
- `alloc_valid` in 1, `alloc_ready` out 1: request handshake.
- `write_desc_addr` out `AXI_ADDR_WIDTH`: allocated region address.
- `write_desc_len` out `LEN_WIDTH`: original, unrounded length.
- `write_desc_tag` out `TAG_WIDTH`: tag of the request.
- `write_desc_valid` out 1, `write_desc_ready` in 1: descriptor handshake to the ingress DMA.
- `free_addr` in `AXI_ADDR_WIDTH`: address of the region to release.
- `free_valid` in 1: release strobe. Always accepted; there is no ready.
- `used_bytes` out `$clog2(BUF_SIZE)+1`: bytes currently allocated, including wrap padding.
- `inflight` out `$clog2(MAX_INFLIGHT)+1`: occupied table slots.
- `alloc_err` out 1: one-cycle pulse, request rejected for length.
- `free_err` out 1: one-cycle pulse, release address matched no slot.

## Operation

- State:
  - `wr_off` and `rd_off`: byte offsets into the buffer.
  - `used`.
  - Slot table: circular FIFO with head and tail indices. Each entry holds `{addr, size, done}`.
- Size computation: `sz = max(ALIGN, roundup(alloc_len, ALIGN))`.
- Wrap handling: if `wr_off + sz > BUF_SIZE`, then `pad = BUF_SIZE - wr_off` and `addr = BUF_BASE`. Otherwise `pad = 0` and `addr = BUF_BASE + wr_off`.
- A request fits when `used + pad + sz <= BUF_SIZE` and `inflight < MAX_INFLIGHT`.
- `alloc_ready = !rst && (!write_desc_valid || write_desc_ready) && (fits || alloc_len > MTU)`.
- On accept with `alloc_len <= MTU`:
  - Push `{addr, pad+sz, 0}` at tail.
  - `wr_off <= (wr_off + pad + sz) mod BUF_SIZE`.
  - `used += pad + sz`.
  - Load the descriptor registers and set `write_desc_valid`.
- On accept with `alloc_len > MTU`: pulse `alloc_err`, emit no descriptor, change no state.
- On a free:
  - Search all occupied, not-done slots for a matching `addr`.
  - Exactly one match: set its `done` bit.
  - No match: pulse `free_err`, change nothing.
- Retire: if the head slot is occupied and done, pop it, advance `rd_off` by its size, and do `used -= size`. At most one retire per cycle.
- An accept and a retire in the same cycle both apply. Net effect: `used += alloc - retire`, and `inflight` is unchanged.
- A free that targets a slot pushed in the same cycle does not match, and `free_err` fires. Upstream must never do this.
- Length 0 allocates one `ALIGN` granule.

## Timing

- Accept to `write_desc_valid`: 1 cycle. The descriptor stays stable until `write_desc_ready`.
- The descriptor stage holds one entry. Back-to-back accepts are possible when `write_desc_ready` is held high.
- Free to done bit: 1 cycle. Done head to retire: 1 cycle, so freeing the head frees space 2 cycles later.
- `alloc_err` is asserted the cycle after the accept. `free_err` is asserted the cycle after the free strobe.
- `used_bytes` and `inflight` are registered and reflect the previous cycle's updates.
- Reset values: all state cleared, including all valid and done bits. Output values after reset:
  - `write_desc_valid`, `alloc_err`, `free_err`: 0.
  - `write_desc_addr`: `BUF_BASE`.
  - `write_desc_len`, `write_desc_tag`: 0.
  - `used_bytes`, `inflight`: 0.
- Reset mid-operation drops every outstanding allocation and any pending descriptor. Frees that arrive afterwards hit `free_err`.

## Structure

- Shared package `pspin_alloc_pkg`:
  - Slot entry typedef.
  - `ALIGN`/`BUF_SIZE` log2 constants.
  - Round-up function.
- The slot table with its CAM search and head/tail logic is a natural sub-module: `pspin_alloc_slot_table`, with push, mark-done-by-address and pop-when-done ports.

## Test plan

Bench configuration: `BUF_SIZE=4096`, `ALIGN=64`, `MAX_INFLIGHT=4`, `BUF_BASE=0x1000`.

- Single request, length 100, tag 0xAB → descriptor `{0x1000, 100, 0xAB}` one cycle after accept; `used=128`, `inflight=1`.
- Wrap: allocate three 1280-byte requests (`wr_off=3840`), free all three, then request length 300 → address `0x1000`, slot size 256+320=576, `used=576`.
- Full: four 64-byte allocations → `alloc_ready` low on the fifth. Free the first → `alloc_ready` high 2 cycles later.
- Out-of-order free: allocate A, B, C; free C, then B → `used` unchanged. Free A → A, B, C retire on 3 consecutive cycles, ending at `used=0`.
- Errors: request length 1501 → `alloc_err` pulse and no descriptor. Free address 0x1040 with nothing outstanding → `free_err` pulse, state unchanged.
- Reset asserted while a descriptor waits on `write_desc_ready` low → `write_desc_valid` goes to 0 and the counters to 0. The next request gets address 0x1000.
